// File: rtl/otter_lsu_if.sv
// OTTER data port 2 bus between the load/store unit and memory.
// The LSU is the master; memory answers on MEM_DOUT2.
interface otter_lsu_if;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_READ2;
  logic        MEM_WRITE2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  modport master (
    output MEM_ADDR2, MEM_DIN2, MEM_READ2,
    output MEM_WRITE2, MEM_SIZE, MEM_SIGN,
    input  MEM_DOUT2
  );

  modport slave (
    input  MEM_ADDR2, MEM_DIN2, MEM_READ2,
    input  MEM_WRITE2, MEM_SIZE, MEM_SIGN,
    output MEM_DOUT2
  );
endinterface

// File: rtl/otter_lsu.sv
// OTTER load/store unit: range-checks requests and splits misaligned
// half/word accesses into byte accesses, reassembling split loads.
module otter_lsu #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter logic [31:0] IO_BASE   = 32'h11000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic [1:0]  SIZE,
  input  logic        SIGN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  otter_lsu_if.master mem
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] BISSUE = 3'd3;
  localparam logic [2:0] BWAIT  = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  logic [2:0]  state;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  size_r;
  logic        sign_r;
  logic        err_r;
  logic [1:0]  k;
  logic [31:0] asm_r;
  logic [31:0] rdata_r;

  logic [2:0]  n_bytes;
  logic [32:0] last_byte;
  logic        is_io;
  logic        misal;
  logic        req_err;
  logic        last_k;
  logic        split;
  logic        issue;
  logic [31:0] asm_n;
  logic [31:0] asm_ext;

  always_comb begin
    unique case (SIZE)
      2'd0:    n_bytes = 3'd1;
      2'd1:    n_bytes = 3'd2;
      default: n_bytes = 3'd4;
    endcase
  end

  // Last touched byte computed 33 bits wide so a wrap cannot hide.
  assign last_byte = {1'b0, ADDR} + {30'b0, n_bytes} - 33'd1;
  assign is_io     = ADDR >= IO_BASE;
  assign misal     = (SIZE == 2'd1) ? ADDR[0] :
                     (SIZE == 2'd2) ? |ADDR[1:0] : 1'b0;
  assign req_err   = (SIZE == 2'd3)
                   | (!is_io && last_byte >= 33'(MEM_BYTES))
                   | (is_io && misal);

  assign last_k = (size_r == 2'd1) ? (k == 2'd1) : (k == 2'd3);

  always_comb begin
    asm_n = asm_r;
    asm_n[8*k +: 8] = mem.MEM_DOUT2[7:0];
  end

  assign asm_ext = (size_r == 2'd1) ?
    {sign_r ? 16'h0 : {16{asm_n[15]}}, asm_n[15:0]} : asm_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      size_r  <= '0;
      sign_r  <= 1'b0;
      err_r   <= 1'b0;
      k       <= '0;
      asm_r   <= '0;
      rdata_r <= '0;
    end else begin
      unique case (state)
        IDLE: if (REQ) begin
          we_r    <= WE;
          addr_r  <= ADDR;
          wdata_r <= WDATA;
          size_r  <= SIZE;
          sign_r  <= SIGN;
          err_r   <= req_err;
          k       <= '0;
          asm_r   <= '0;
          if (req_err)
            state <= FIN;
          else if (!misal || is_io)
            state <= ISSUE;
          else
            state <= BISSUE;
        end
        ISSUE: state <= we_r ? FIN : WAIT;
        WAIT: begin
          rdata_r <= mem.MEM_DOUT2;
          state   <= FIN;
        end
        BISSUE: begin
          if (!we_r)
            state <= BWAIT;
          else if (last_k)
            state <= FIN;
          else
            k <= k + 2'd1;
        end
        BWAIT: begin
          asm_r <= asm_n;
          if (last_k) begin
            rdata_r <= asm_ext;
            state   <= FIN;
          end else begin
            k     <= k + 2'd1;
            state <= BISSUE;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign split = (state == BISSUE) || (state == BWAIT);
  assign issue = (state == ISSUE) || (state == BISSUE);

  assign mem.MEM_ADDR2  = split ? addr_r + {30'b0, k} : addr_r;
  assign mem.MEM_DIN2   = split ? {24'b0, wdata_r[8*k +: 8]} : wdata_r;
  assign mem.MEM_SIZE   = split ? 2'd0 : size_r;
  assign mem.MEM_SIGN   = split ? 1'b1 : sign_r;
  assign mem.MEM_READ2  = issue & !we_r;
  assign mem.MEM_WRITE2 = issue & we_r;

  assign BUSY  = state != IDLE;
  assign DONE  = state == FIN;
  assign ERR   = (state == FIN) & err_r;
  assign RDATA = rdata_r;

endmodule

// File: tb/tb_otter_lsu.sv
// Directed bench for otter_lsu with a byte-addressed memory model
// and a scoreboard of expected completion latency/result per request.
module tb_otter_lsu;

  localparam logic [31:0] IO_BASE = 32'h11000000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] WDATA = '0;
  logic [1:0]  SIZE = '0;
  logic        SIGN = 1'b0;
  logic        BUSY, DONE, ERR;
  logic [31:0] RDATA;

  otter_lsu_if bus();

  otter_lsu dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE),
    .ADDR(ADDR), .WDATA(WDATA), .SIZE(SIZE), .SIGN(SIGN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
    .mem(bus)
  );

  always #5 CLK = ~CLK;

  logic [7:0]  mem [0:65535];
  logic [31:0] io_addr = '0;
  logic [31:0] io_din = '0;
  int          wr_n = 0;
  int          rd_n = 0;
  int          both_n = 0;

  function automatic logic [31:0] rd_val(input logic [31:0] a,
                                         input logic [1:0] sz,
                                         input logic sg);
    logic [15:0] i;
    logic [31:0] w;
    i = a[15:0];
    if (a >= 32'd65536) return '0;
    w = {mem[i + 16'd3], mem[i + 16'd2], mem[i + 16'd1], mem[i]};
    case (sz)
      2'd0:    return {sg ? 24'h0 : {24{w[7]}}, w[7:0]};
      2'd1:    return {sg ? 16'h0 : {16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory: writes land at the edge, reads registered one cycle.
  always @(posedge CLK) begin
    if (bus.MEM_WRITE2) wr_n++;
    if (bus.MEM_READ2) rd_n++;
    if (bus.MEM_WRITE2 && bus.MEM_READ2) both_n++;
    if (bus.MEM_WRITE2) begin
      if (bus.MEM_ADDR2 < 32'd65536) begin
        mem[bus.MEM_ADDR2[15:0]] <= bus.MEM_DIN2[7:0];
        if (bus.MEM_SIZE != 2'd0)
          mem[bus.MEM_ADDR2[15:0] + 16'd1] <= bus.MEM_DIN2[15:8];
        if (bus.MEM_SIZE == 2'd2) begin
          mem[bus.MEM_ADDR2[15:0] + 16'd2] <= bus.MEM_DIN2[23:16];
          mem[bus.MEM_ADDR2[15:0] + 16'd3] <= bus.MEM_DIN2[31:24];
        end
      end else if (bus.MEM_ADDR2 >= IO_BASE) begin
        io_addr <= bus.MEM_ADDR2;
        io_din  <= bus.MEM_DIN2;
      end
    end
    if (bus.MEM_READ2)
      bus.MEM_DOUT2 <= rd_val(bus.MEM_ADDR2, bus.MEM_SIZE, bus.MEM_SIGN);
  end

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rd;
    bit          chk_rd;
    int          nw;
    int          nr;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input bit we,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [1:0] sz, input bit sg,
                    input int lat, input bit err,
                    input logic [31:0] rd, input int nw, input int nr);
    exp_t e;
    int   n;
    int   w0;
    int   r0;
    if (!we && !err) last_rd = rd;
    e = '{lat, err, last_rd, !err, nw, nr};
    q.push_back(e);
    @(negedge CLK);
    w0 = wr_n;
    r0 = rd_n;
    REQ = 1'b1; WE = we; ADDR = a; WDATA = wd; SIZE = sz; SIGN = sg;
    @(posedge CLK);
    #1 REQ = 1'b0;
    n = 1;
    while (!DONE && n < 40) begin
      @(posedge CLK);
      #1 n++;
    end
    e = q.pop_front();
    chk({tag, " lat"}, 32'(n), 32'(e.lat));
    chk({tag, " err"}, {31'b0, ERR}, {31'b0, e.err});
    if (e.chk_rd) chk({tag, " rdata"}, RDATA, e.rd);
    chk({tag, " writes"}, 32'(wr_n - w0), 32'(e.nw));
    chk({tag, " reads"}, 32'(rd_n - r0), 32'(e.nr));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    chk("rst busy", {31'b0, BUSY}, 32'd0);
    chk("rst done", {31'b0, DONE}, 32'd0);
    chk("rst err", {31'b0, ERR}, 32'd0);
    chk("rst rdata", RDATA, 32'd0);
    chk("rst addr", bus.MEM_ADDR2, 32'd0);
    chk("rst din", bus.MEM_DIN2, 32'd0);
    chk("rst strobes", {28'b0, bus.MEM_READ2, bus.MEM_WRITE2,
                        bus.MEM_SIZE}, 32'd0);
    chk("rst sign", {31'b0, bus.MEM_SIGN}, 32'd0);

    op("sw100", 1, 32'h100, 32'hDEADBEEF, 2, 0, 2, 0, 0, 1, 0);
    op("lw100", 0, 32'h100, 0, 2, 0, 3, 0, 32'hDEADBEEF, 0, 1);

    op("sw201", 1, 32'h201, 32'h11223344, 2, 0, 5, 0, 0, 4, 0);
    chk("m201", {24'b0, mem[16'h201]}, 32'h44);
    chk("m202", {24'b0, mem[16'h202]}, 32'h33);
    chk("m203", {24'b0, mem[16'h203]}, 32'h22);
    chk("m204", {24'b0, mem[16'h204]}, 32'h11);
    op("lw201", 0, 32'h201, 0, 2, 0, 9, 0, 32'h11223344, 0, 4);

    op("sb203", 1, 32'h203, 32'h80, 0, 0, 2, 0, 0, 1, 0);
    op("sb204", 1, 32'h204, 32'hFF, 0, 0, 2, 0, 0, 1, 0);
    op("lh203", 0, 32'h203, 0, 1, 0, 5, 0, 32'hFFFFFF80, 0, 2);
    op("lhu203", 0, 32'h203, 0, 1, 1, 5, 0, 32'h0000FF80, 0, 2);
    op("lb203", 0, 32'h203, 0, 0, 0, 3, 0, 32'hFFFFFF80, 0, 1);

    op("lw10000", 0, 32'h10000, 0, 2, 0, 1, 1, 0, 0, 0);
    op("swFFFE", 1, 32'hFFFE, 32'h1, 2, 0, 1, 1, 0, 0, 0);
    op("size3", 0, 32'h100, 0, 3, 0, 1, 1, 0, 0, 0);
    op("lhFFFF", 0, 32'hFFFF, 0, 1, 0, 1, 1, 0, 0, 0);
    op("swFFFC", 1, 32'hFFFC, 32'hCAFEF00D, 2, 0, 2, 0, 0, 1, 0);
    op("lwFFFC", 0, 32'hFFFC, 0, 2, 0, 3, 0, 32'hCAFEF00D, 0, 1);

    op("swio", 1, IO_BASE, 32'h5, 2, 0, 2, 0, 0, 1, 0);
    chk("io addr", io_addr, IO_BASE);
    chk("io din", io_din, 32'h5);
    op("swio2", 1, IO_BASE + 32'd2, 32'h7, 2, 0, 1, 1, 0, 0, 0);

    op("sb303", 1, 32'h303, 32'hAA, 0, 0, 2, 0, 0, 1, 0);
    op("sb304", 1, 32'h304, 32'hBB, 0, 0, 2, 0, 0, 1, 0);
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b1; ADDR = 32'h301;
    WDATA = 32'h44332211; SIZE = 2'd2; SIGN = 1'b0;
    @(posedge CLK);
    #1 REQ = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    chk("abort busy", {31'b0, BUSY}, 32'd0);
    chk("abort rdata", RDATA, 32'd0);
    chk("abort m301", {24'b0, mem[16'h301]}, 32'h11);
    chk("abort m302", {24'b0, mem[16'h302]}, 32'h22);
    chk("abort m303", {24'b0, mem[16'h303]}, 32'hAA);
    chk("abort m304", {24'b0, mem[16'h304]}, 32'hBB);
    last_rd = '0;
    op("lw301", 0, 32'h301, 0, 2, 0, 9, 0, 32'hBBAA2211, 0, 4);

    chk("strobe overlap", 32'(both_n), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
